// File: rtl/sram_c_pkg.sv
// Shared definitions for the C-operand SRAM read path: geometry, word type,
// sequencer state encoding and the wrapping address increment.
package sram_c_pkg;

   localparam int Es          = 16;
   localparam int COL         = 64;
   localparam int sram_addr_c = 6;
   localparam int WORD_W      = Es * 3;

   localparam logic [sram_addr_c-1:0] LAST_ADDR = sram_addr_c'(COL - 1);
   localparam logic [sram_addr_c:0]   CNT_ONE   = (sram_addr_c + 1)'(1);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Addresses run modulo COL, which need not be a power of two.
   function automatic logic [sram_addr_c-1:0] next_addr(input logic [sram_addr_c-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

endpackage

// File: rtl/sram_c_rd_fifo.sv
// Two-entry synchronous FIFO holding captured SRAM words; head is visible
// combinationally, so the stream data is stable until it is popped.
module sram_c_rd_fifo
   import sram_c_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  word_t      din,
   input  logic       pop,
   output word_t      dout,
   output logic [1:0] count
);

   word_t      mem_reg [2];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       push_ok;
   logic       pop_ok;

   assign push_ok = push && (count_reg != 2'd2);
   assign pop_ok  = pop && (count_reg != 2'd0);

   // Entries are cleared on reset so every stream output reads 0 afterwards.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               mem_reg[gi] <= '0;
            else if (push_ok && (wr_ptr_reg == 1'(gi)))
               mem_reg[gi] <= din;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_ok)
            rd_ptr_reg <= ~rd_ptr_reg;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/sram_c_rd_ctrl.sv
// Burst read sequencer for the C-operand SRAM feeding a valid/ready stream.
// Define SRAM_C_RD_LAST_EN to add the m_last end-of-burst marker.
module sram_c_rd_ctrl
   import sram_c_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [sram_addr_c-1:0] base_addr,
   input  logic [sram_addr_c:0]   len,
   output logic                   busy,
   output logic                   done,
   output logic                   rd_en,
   output logic [sram_addr_c-1:0] rd_addr,
   input  word_t                  data_in,
   input  logic                   data_in_vld,
   output word_t                  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
`ifdef SRAM_C_RD_LAST_EN
   output logic                   m_last,
`endif
   output logic                   err
);

   state_t                 state_reg;
   logic [sram_addr_c-1:0] addr_reg;
   logic [sram_addr_c:0]   issue_cnt_reg;
   logic [sram_addr_c:0]   beat_cnt_reg;
   logic                   outstanding_reg;
   logic                   busy_reg;
   logic                   done_reg;
   logic                   err_reg;
   logic [1:0]             fifo_count;
   logic                   push;
   logic                   pop;

   sram_c_rd_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (data_in),
      .pop   (pop),
      .dout  (m_data),
      .count (fifo_count)
   );

   assign push    = data_in_vld && outstanding_reg;
   assign m_valid = (fifo_count != 2'd0);
   assign pop     = m_valid && m_ready;

   // Credit check uses only registered state, so rd_en moves on clock edges;
   // with two slots this allows at most two reads in any three cycles.
   assign rd_en = (state_reg == ISSUE) && (issue_cnt_reg != '0) &&
                  ((fifo_count + {1'b0, outstanding_reg}) < 2'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         issue_cnt_reg   <= '0;
         beat_cnt_reg    <= '0;
         outstanding_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         done_reg        <= 1'b0;
         outstanding_reg <= rd_en;
         if (data_in_vld && !outstanding_reg)
            err_reg <= 1'b1;
         if (pop)
            beat_cnt_reg <= beat_cnt_reg - 1'b1;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state_reg     <= ISSUE;
                     busy_reg      <= 1'b1;
                     addr_reg      <= base_addr;
                     issue_cnt_reg <= len;
                     beat_cnt_reg  <= len;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (rd_en) begin
                  addr_reg      <= next_addr(addr_reg);
                  issue_cnt_reg <= issue_cnt_reg - 1'b1;
                  if (issue_cnt_reg == CNT_ONE)
                     state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && (beat_cnt_reg == CNT_ONE)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rd_addr = addr_reg;
   assign err     = err_reg;

`ifdef SRAM_C_RD_LAST_EN
   assign m_last = m_valid && (beat_cnt_reg == CNT_ONE);
`endif

endmodule

// File: tb/tb_sram_c_rd_ctrl.sv
// Directed bench for sram_c_rd_ctrl with a 1-cycle SRAM model holding mem[i]=i.
module tb_sram_c_rd_ctrl;
   import sram_c_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   start = 1'b0;
   logic [sram_addr_c-1:0] base_addr = '0;
   logic [sram_addr_c:0]   len = '0;
   logic                   busy;
   logic                   done;
   logic                   rd_en;
   logic [sram_addr_c-1:0] rd_addr;
   word_t                  data_in = '0;
   logic                   data_in_vld = 1'b0;
   word_t                  m_data;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic                   err;
`ifdef SRAM_C_RD_LAST_EN
   logic                   m_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic                   sram_pend = 1'b0;
   logic [sram_addr_c-1:0] sram_addr = '0;

   // Hand-derived trace for base 0, len 4, m_ready=1; bit c-1 is cycle c.
   localparam logic [8:0] T1_RD    = 9'h01B;
   localparam logic [8:0] T1_VALID = 9'h06C;
   localparam logic [8:0] T1_DONE  = 9'h080;
   localparam logic [8:0] T1_BUSY  = 9'h07F;

   always #5 clk = ~clk;

   sram_c_rd_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .data_in     (data_in),
      .data_in_vld (data_in_vld),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
`ifdef SRAM_C_RD_LAST_EN
      .m_last      (m_last),
`endif
      .err         (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and play the SRAM: data returns one cycle after rd_en.
   task automatic tick();
      @(posedge clk);
      #1;
      data_in_vld = sram_pend;
      data_in     = word_t'(sram_addr);
      sram_pend   = rd_en;
      sram_addr   = rd_addr;
   endtask

   task automatic test_basic();
      int rd_idx = 0;
      int pop_idx = 0;
      tick();
      start = 1'b1; base_addr = 6'd0; len = 7'd4; m_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         start = 1'b0;
         check("t1_rd_en", rd_en, T1_RD[c-1]);
         check("t1_valid", m_valid, T1_VALID[c-1]);
         check("t1_done", done, T1_DONE[c-1]);
         check("t1_busy", busy, T1_BUSY[c-1]);
         if (rd_en) begin
            check("t1_rd_addr", rd_addr, rd_idx);
            rd_idx++;
         end
         if (m_valid) begin
            check("t1_data", m_data, pop_idx);
            pop_idx++;
         end
      end
      $display("burst base=0 len=4 directed trace: reads=%0d words=%0d", rd_idx, pop_idx);
   endtask

   task automatic run_burst(input int base, input int ln, input bit toggle_ready, input int bad_start_cyc);
      int    cyc = 0;
      int    pops = 0;
      int    issued = 0;
      int    model_cnt = 0;
      bit    got_done = 1'b0;
      bit    prev_hold = 1'b0;
      word_t held = '0;
      logic  [3:0] pat = 4'b1001;
      logic  popped;
      tick();
      start = 1'b1; base_addr = sram_addr_c'(base); len = (sram_addr_c + 1)'(ln); m_ready = 1'b1;
      while (!got_done && cyc < 400) begin
         tick();
         cyc++;
         start = (cyc == bad_start_cyc);
         if (start) begin
            base_addr = 6'd40;
            len       = 7'd2;
         end
         m_ready = toggle_ready ? pat[cyc % 4] : 1'b1;
         if (prev_hold) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_data", m_data, held);
         end
         if (rd_en) begin
            check("credit", ((model_cnt + int'(data_in_vld)) < 2), 1'b1);
            check("rd_addr", rd_addr, (base + issued) % COL);
            issued++;
         end
         if (done) begin
            got_done = 1'b1;
            check("busy_at_done", busy, 1'b0);
            check("pops_at_done", pops, ln);
         end
         popped = m_valid && m_ready;
         if (popped) begin
            check("data", m_data, word_t'((base + pops) % COL));
`ifdef SRAM_C_RD_LAST_EN
            check("m_last", m_last, (pops == ln - 1));
`endif
            pops++;
         end
         prev_hold = m_valid && !m_ready;
         held      = m_data;
         model_cnt = model_cnt + int'(data_in_vld) - int'(popped);
      end
      check("done_seen", got_done, 1'b1);
      check("issued", issued, ln);
      start = 1'b0;
      tick();
      check("done_one_cycle", done, 1'b0);
      $display("burst base=%0d len=%0d ready_toggle=%0d reads=%0d words=%0d cycles=%0d",
               base, ln, toggle_ready, issued, pops, cyc);
   endtask

   initial begin
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_data", m_data, 0);
      check("rst_err", err, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      test_basic();
      run_burst(62, 4, 1'b0, 0);
      run_burst(7, 8, 1'b1, 0);
      run_burst(10, 4, 1'b0, 2);
      run_burst(5, 64, 1'b0, 0);
      run_burst(20, 3, 1'b1, 0);

      // Zero-length request: done next cycle, nothing issued, never busy.
      tick();
      start = 1'b1; base_addr = 6'd3; len = 7'd0;
      tick();
      start = 1'b0;
      check("len0_done", done, 1'b1);
      check("len0_busy", busy, 1'b0);
      check("len0_rd_en", rd_en, 1'b0);
      tick();
      check("len0_done_clear", done, 1'b0);
      check("len0_rd_en2", rd_en, 1'b0);
      $display("burst base=3 len=0 done=%0d", 1);

      // Stray return with nothing outstanding.
      tick();
      data_in_vld = 1'b1;
      data_in     = word_t'(48'hABC);
      tick();
      check("stray_err", err, 1'b1);
      check("stray_valid", m_valid, 1'b0);
      tick();
      tick();
      check("stray_err_sticky", err, 1'b1);
      $display("stray data_in_vld err=%0d", err);

      // Asynchronous reset in the middle of a stalled burst.
      tick();
      start = 1'b1; base_addr = 6'd0; len = 7'd8; m_ready = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("mid_busy", busy, 1'b1);
      check("mid_valid", m_valid, 1'b1);
      #3;
      rst = 1'b0;
      sram_pend = 1'b0;
      data_in_vld = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_rd_en", rd_en, 1'b0);
      check("arst_rd_addr", rd_addr, 0);
      check("arst_valid", m_valid, 1'b0);
      check("arst_data", m_data, 0);
      check("arst_err", err, 1'b0);
      #1;
      rst = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_done", done, 1'b0);
         check("post_rst_busy", busy, 1'b0);
         check("post_rst_valid", m_valid, 1'b0);
      end
      $display("async reset mid-burst handled");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
